axi_wr_ctrl: RTL and testbench

AXI4 write-channel slave that converts AW/W bursts into single-beat memory write requests (`wr_en`, `wr_addr`, `wr_strobe`, `data`) for the ECC encoding stage directly downstream, and returns one B response per burst. The ECC encoder and memory accept one write per cycle with no backpressure, so this block paces the write path entirely through AXI `wready`.

---
 rtl/axi_wr_ctrl.sv | 160 ++++++++++++++++
 tb/tb_axi_wr_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_ctrl.sv
// AXI4 write-channel slave: splits AW/W bursts into single-beat write requests and returns one B per burst.
// Optional define AXI_WR_4K_CHECK_EN flags INCR bursts that cross a 4 KB boundary.
module axi_wr_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  axi_wr_clk,
  input  logic                  axi_wr_rst,
  input  logic                  axi_wr_sw_rst,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_WIDTH-1:0]   bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [3:0]            wr_strobe_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_r;
  logic [ID_WIDTH-1:0]   id_r;
  logic [7:0]            len_r;
  logic                  incr_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [7:0]            cnt_r;
  logic                  err_r;       // suppresses writes for the whole burst
  logic                  resp_err_r;  // WLAST mismatch: affects only the response

  logic                  aw_bad_s;
  logic                  last_beat_s;
  logic                  wlast_bad_s;
  logic [13:0]           last_off_s;

  // Burst legality at AW time and per-beat WLAST bookkeeping.
  always_comb begin
    last_off_s  = {2'b00, awaddr[11:2], 2'b00} + {4'b0000, awlen, 2'b00};
    aw_bad_s    = (awsize != 3'b010) || (awburst[1] == 1'b1);
`ifdef AXI_WR_4K_CHECK_EN
    aw_bad_s    = aw_bad_s || ((awburst == 2'b01) && (last_off_s > 14'h0FFF));
`endif
    last_beat_s = (cnt_r == len_r);
    wlast_bad_s = (wlast != last_beat_s);
  end

  // Control FSM with registered handshake and write-request outputs.
  always_ff @(posedge axi_wr_clk or posedge axi_wr_rst) begin
    if (axi_wr_rst) begin
      state_r     <= IDLE;
      id_r        <= '0;
      len_r       <= 8'd0;
      incr_r      <= 1'b0;
      addr_r      <= '0;
      cnt_r       <= 8'd0;
      err_r       <= 1'b0;
      resp_err_r  <= 1'b0;
      awready     <= 1'b1;
      wready      <= 1'b0;
      bvalid      <= 1'b0;
      bid         <= '0;
      bresp       <= 2'b00;
      wr_en_o     <= 1'b0;
      wr_addr_o   <= '0;
      wr_strobe_o <= 4'b0000;
      data_o      <= '0;
    end else if (axi_wr_sw_rst) begin
      state_r     <= IDLE;
      id_r        <= '0;
      len_r       <= 8'd0;
      incr_r      <= 1'b0;
      addr_r      <= '0;
      cnt_r       <= 8'd0;
      err_r       <= 1'b0;
      resp_err_r  <= 1'b0;
      awready     <= 1'b1;
      wready      <= 1'b0;
      bvalid      <= 1'b0;
      bid         <= '0;
      bresp       <= 2'b00;
      wr_en_o     <= 1'b0;
      wr_addr_o   <= '0;
      wr_strobe_o <= 4'b0000;
      data_o      <= '0;
    end else begin
      wr_en_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (awvalid) begin
            id_r       <= awid;
            len_r      <= awlen;
            incr_r     <= (awburst == 2'b01);
            addr_r     <= {awaddr[ADDR_WIDTH-1:2], 2'b00};
            cnt_r      <= 8'd0;
            err_r      <= aw_bad_s;
            resp_err_r <= 1'b0;
            awready    <= 1'b0;
            wready     <= 1'b1;
            state_r    <= DATA;
          end
        end
        DATA: begin
          if (wvalid) begin
            if (!err_r) begin
              wr_en_o     <= 1'b1;
              wr_addr_o   <= addr_r;
              wr_strobe_o <= wstrb;
              data_o      <= wdata;
            end
            if (incr_r) begin
              addr_r <= addr_r + ADDR_WIDTH'(3'd4);
            end
            if (wlast_bad_s) begin
              resp_err_r <= 1'b1;
            end
            cnt_r <= cnt_r + 8'd1;
            if (last_beat_s) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bid     <= id_r;
              bresp   <= (err_r || resp_err_r || wlast_bad_s) ? 2'b10 : 2'b00;
              state_r <= RESP;
            end
          end
        end
        RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          awready <= 1'b1;
          wready  <= 1'b0;
          bvalid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_ctrl.sv
// Self-checking bench for axi_wr_ctrl: directed test-plan bursts plus random bursts checked
// against expected writes and responses computed from burst parameters.
module tb_axi_wr_ctrl;

  logic        clk = 1'b0;
  logic        rst, sw_rst;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic        wr_en_o;
  logic [31:0] wr_addr_o;
  logic [3:0]  wr_strobe_o;
  logic [31:0] data_o;

  int total = 0;
  int bad = 0;
  int wr_seen = 0;

  axi_wr_ctrl dut (
    .axi_wr_clk(clk), .axi_wr_rst(rst), .axi_wr_sw_rst(sw_rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_strobe_o(wr_strobe_o), .data_o(data_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_en_o === 1'b1) wr_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_awready"}, awready, 32'd1);
    chk({tag, "_wready"}, wready, 32'd0);
    chk({tag, "_bvalid"}, bvalid, 32'd0);
    chk({tag, "_bid"}, bid, 32'd0);
    chk({tag, "_bresp"}, bresp, 32'd0);
    chk({tag, "_wr_en"}, wr_en_o, 32'd0);
    chk({tag, "_wr_addr"}, wr_addr_o, 32'd0);
    chk({tag, "_strobe"}, wr_strobe_o, 32'd0);
    chk({tag, "_data"}, data_o, 32'd0);
  endtask

  // lmode: 0 = correct wlast, 1 = extra wlast on beat lbeat, 2 = wlast never asserted
  task automatic burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] bt, input int lmode,
                       input int lbeat, input logic [31:0] d0, input logic [3:0] s0,
                       input int gap_max, input int bstall);
    logic [31:0] base, ea, d;
    logic [3:0]  s;
    logic        errf, mism, wl;
    int          exp_wr, start, w, g;
    errf = (size != 3'b010) || (bt > 2'd1);
    base = addr & 32'hFFFF_FFFC;
`ifdef AXI_WR_4K_CHECK_EN
    if (bt == 2'd1 && (int'(base[11:0]) + 4 * int'(len) > 4095)) errf = 1'b1;
`endif
    mism   = 1'b0;
    exp_wr = errf ? 0 : int'(len) + 1;
    start  = wr_seen;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = bt; awvalid = 1'b1;
    w = 0;
    while (awready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    chk("aw_timeout", 32'(w < 50), 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
    chk("wready_after_aw", wready, 32'd1);
    chk("awready_busy", awready, 32'd0);
    for (int i = 0; i <= int'(len); i++) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      if (g > 0) begin
        wvalid = 1'b0;
        repeat (g) @(negedge clk);
        chk("idle_no_wr", wr_en_o, 32'd0);
      end
      wl = (lmode == 0) ? (i == int'(len)) : (lmode == 1) ? (i == int'(len) || i == lbeat) : 1'b0;
      if (wl != (i == int'(len))) mism = 1'b1;
      d = d0 + 32'(i);
      s = s0 ^ 4'(i);
      wdata = d; wstrb = s; wlast = wl; wvalid = 1'b1;
      w = 0;
      while (wready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
      chk("w_stall", w, 32'd0);
      @(negedge clk);
      ea = (bt == 2'd1) ? base + 32'(4 * i) : base;
      chk("wr_en", wr_en_o, 32'(!errf));
      if (!errf) begin
        chk("wr_addr", wr_addr_o, ea);
        chk("wr_strobe", wr_strobe_o, 32'(s));
        chk("wr_data", data_o, d);
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid", bvalid, 32'd1);
    chk("bid", bid, 32'(id));
    chk("bresp", bresp, (errf || mism) ? 32'd2 : 32'd0);
    chk("wready_resp", wready, 32'd0);
    for (int k = 0; k < bstall; k++) begin
      @(negedge clk);
      chk("bvalid_hold", bvalid, 32'd1);
      chk("bid_hold", bid, 32'(id));
      chk("bresp_hold", bresp, (errf || mism) ? 32'd2 : 32'd0);
      chk("awready_in_resp", awready, 32'd0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("bvalid_done", bvalid, 32'd0);
    chk("awready_done", awready, 32'd1);
    #1;
    chk("wr_count", 32'(wr_seen - start), 32'(exp_wr));
  endtask

  initial begin
    logic [31:0] r, a;
    logic [2:0]  sz;
    logic [1:0]  bt;
    logic [7:0]  ln;
    int          lm, lb;
    rst = 1'b1; sw_rst = 1'b0; bready = 1'b0;
    awid = 4'h0; awaddr = 32'h0; awlen = 8'h0; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b0;
    wdata = 32'h0; wstrb = 4'h0; wlast = 1'b0; wvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    rst = 1'b0;

    // W presented before AW must wait
    @(negedge clk);
    wvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'hF; wlast = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("w_before_aw_wready", wready, 32'd0);
      chk("w_before_aw_wr_en", wr_en_o, 32'd0);
    end
    wvalid = 1'b0;

    burst(4'h3, 32'h100, 8'd0, 3'b010, 2'b01, 0, 0, 32'hDEAD_BEEF, 4'hF, 0, 0);
    burst(4'h5, 32'h200, 8'd3, 3'b010, 2'b01, 0, 0, 32'hA000_0000, 4'hF, 0, 0);
    burst(4'h6, 32'h40, 8'd2, 3'b010, 2'b00, 0, 0, 32'hB000_0000, 4'h3, 0, 0);
    burst(4'h7, 32'h43, 8'd0, 3'b010, 2'b00, 0, 0, 32'hC000_0000, 4'h8, 0, 0);
    burst(4'h8, 32'h400, 8'd2, 3'b001, 2'b01, 0, 0, 32'hD000_0000, 4'hF, 0, 0);
    burst(4'h9, 32'h400, 8'd2, 3'b010, 2'b10, 0, 0, 32'hE000_0000, 4'hF, 0, 0);
    burst(4'hA, 32'h500, 8'd3, 3'b010, 2'b01, 1, 1, 32'hF000_0000, 4'hF, 0, 0);
    burst(4'hB, 32'h600, 8'd1, 3'b010, 2'b01, 2, 0, 32'h1100_0000, 4'hF, 0, 0);
    burst(4'hC, 32'h700, 8'd1, 3'b010, 2'b01, 0, 0, 32'h2200_0000, 4'h0, 0, 5);
    burst(4'hD, 32'hFF8, 8'd3, 3'b010, 2'b01, 0, 0, 32'h3300_0000, 4'hF, 0, 0);
    burst(4'hE, 32'hFFFF_FFF8, 8'd3, 3'b010, 2'b01, 0, 0, 32'h4400_0000, 4'hF, 0, 0);

    // async reset mid-burst
    @(negedge clk);
    awid = 4'h2; awaddr = 32'h300; awlen = 8'd3; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b1; wdata = 32'h5555_AAAA; wstrb = 4'hF; wlast = 1'b0;
    @(negedge clk);
    chk("pre_rst_wr_en", wr_en_o, 32'd1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("arst");
    wvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    burst(4'h1, 32'h800, 8'd1, 3'b010, 2'b01, 0, 0, 32'h6600_0000, 4'hF, 0, 0);

    // soft reset mid-burst
    @(negedge clk);
    awid = 4'h4; awaddr = 32'h900; awlen = 8'd3; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b1; wdata = 32'h7777_0000; wstrb = 4'hF; wlast = 1'b0;
    @(negedge clk);
    sw_rst = 1'b1; wvalid = 1'b0;
    @(negedge clk);
    chk_reset_vals("srst");
    sw_rst = 1'b0;
    burst(4'hF, 32'hA00, 8'd2, 3'b010, 2'b00, 0, 0, 32'h8800_0000, 4'h5, 0, 0);

    // random bursts
    for (int n = 0; n < 40; n++) begin
      r  = $urandom;
      sz = (r[3:0] == 4'd0) ? 3'b001 : 3'b010;
      bt = (r[7:4] == 4'd0) ? 2'b10 : (r[7:4] < 4'd5) ? 2'b00 : 2'b01;
      ln = 8'($urandom_range(7, 0));
      lm = (r[11:8] == 4'd0) ? 1 : (r[11:8] == 4'd1) ? 2 : 0;
      lb = (ln > 8'd0) ? int'($urandom_range(int'(ln) - 1, 0)) : 0;
      a  = $urandom;
      if (r[12]) a[11:0] = 12'hFE0 | 12'($urandom_range(31, 0));
      burst(r[19:16], a, ln, sz, bt, lm, lb, $urandom, r[23:20], int'(r[25:24]), int'(r[28:26]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
